// File: rtl/mem_io_pkg.sv
// Shared definitions for the data-memory load/run/dump sequencer.
// Contents:
//   state_t   - sequencer state encoding
//   MUX_*     - addr_mux_select codes driven towards the matmul `top`
//   CNT_W     - width of every address / latency counter
//   term_of() - terminal-count value for a counter that must see n values
package mem_io_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    STRT   = 3'd3,
    RUN    = 3'd4,
    DUMP_A = 3'd5,
    DUMP_O = 3'd6
  } state_t;

  localparam logic [1:0] MUX_CORE = 2'd0;
  localparam logic [1:0] MUX_LOAD = 2'd1;
  localparam logic [1:0] MUX_DUMP = 2'd2;

  // Last count value of a run of n counts starting at 0 (n=0 maps to 0).
  function automatic logic [CNT_W-1:0] term_of(input int n);
    if (n <= 0) begin
      return {CNT_W{1'b0}};
    end else begin
      return CNT_W'(n - 1);
    end
  endfunction

endpackage

// File: rtl/mem_io_addr_counter.sv
// Up-counter with synchronous clear, enable and terminal-count compare.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset (count returns to 0)
//   clr     - synchronous clear, wins over en
//   en      - increment by one
//   term    - terminal value compared against the current count
//   count   - registered count
//   at_term - high while count equals term
module mem_io_addr_counter
  import mem_io_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  // Count register: reset/clear to zero, otherwise step on enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (clr) begin
      count <= {CNT_W{1'b0}};
    end else if (en) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/mem_io_sequencer.sv
// Hardware load/run/dump sequencer around the multicore matmul `top`.
// Streams LOAD_WORDS words into dmem through the load port, pulses START,
// waits for END, then streams DUMP_WORDS words back out of dmem.
// Every output is a register; the FSM assigns the values that belong to
// the state it is entering.
// Ports:
//   clk, RESET               - clock, synchronous active-low reset
//   go / busy / done / err   - sequence control and status
//   load_data/valid/ready    - input word stream (ready only in LOAD)
//   addr_mux_select          - 0=core, 1=load, 2=dump, to `top`
//   current_addr, mem_data,
//   write_from_tb            - dmem write port, to `top`
//   ar_in, dmem_rdata        - dmem read port for the dump
//   START, END               - core start pulse / completion level
//   dump_data/valid/ready    - output word stream
module mem_io_sequencer
  import mem_io_pkg::*;
#(
  parameter int LOAD_WORDS  = 1000,
  parameter int DUMP_WORDS  = 997,
  parameter int RD_LAT      = 1,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [1:0]  addr_mux_select,
  output logic [15:0] current_addr,
  output logic [15:0] mem_data,
  output logic        write_from_tb,
  output logic [15:0] ar_in,
  output logic        START,
  input  logic        END,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] dump_data,
  output logic        dump_valid,
  input  logic        dump_ready
);

  // Parameter legality is checked at elaboration.
  if (LOAD_WORDS < 1 || LOAD_WORDS > 65535) begin : g_bad_load_words
    $error("mem_io_sequencer: LOAD_WORDS must be in 1..65535");
  end
  if (DUMP_WORDS < 1 || DUMP_WORDS > 65535) begin : g_bad_dump_words
    $error("mem_io_sequencer: DUMP_WORDS must be in 1..65535");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mem_io_sequencer: RD_LAT must be in 1..3");
  end
  if (RUN_TIMEOUT < 0 || RUN_TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_io_sequencer: RUN_TIMEOUT must be in 0..65535");
  end

  localparam logic [CNT_W-1:0] LOAD_TERM    = term_of(LOAD_WORDS);
  localparam logic [CNT_W-1:0] DUMP_TERM    = term_of(DUMP_WORDS);
  localparam logic [CNT_W-1:0] RDLAT_TERM   = term_of(RD_LAT);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = term_of(RUN_TIMEOUT);
  localparam logic             TIMEOUT_EN   = (RUN_TIMEOUT != 0);

  state_t           state_r;

  logic             addr_clr_s;
  logic             addr_en_s;
  logic [CNT_W-1:0] addr_term_s;
  logic [CNT_W-1:0] addr_count_s;
  logic             addr_at_term_s;

  logic             lat_clr_s;
  logic             lat_en_s;
  logic [CNT_W-1:0] lat_term_s;
  logic [CNT_W-1:0] lat_count_unused;
  logic             lat_at_term_s;

  logic             load_fire_s;
  logic             dump_fire_s;

  // Load/dump word address: cleared on go and again when the dump begins.
  mem_io_addr_counter u_addr_cnt (
    .clk     (clk),
    .rst_n   (RESET),
    .clr     (addr_clr_s),
    .en      (addr_en_s),
    .term    (addr_term_s),
    .count   (addr_count_s),
    .at_term (addr_at_term_s)
  );

  // Shared counter: RUN cycles for the timeout, DUMP_A cycles for RD_LAT.
  mem_io_addr_counter u_lat_cnt (
    .clk     (clk),
    .rst_n   (RESET),
    .clr     (lat_clr_s),
    .en      (lat_en_s),
    .term    (lat_term_s),
    .count   (lat_count_unused),
    .at_term (lat_at_term_s)
  );

  // Counter controls and handshake qualifiers for the current state.
  always_comb begin
    addr_clr_s  = 1'b0;
    addr_en_s   = 1'b0;
    addr_term_s = DUMP_TERM;
    lat_clr_s   = 1'b1;
    lat_en_s    = 1'b0;
    lat_term_s  = RDLAT_TERM;
    load_fire_s = 1'b0;
    dump_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (go) begin
          addr_clr_s = 1'b1;
        end else begin
          addr_clr_s = 1'b0;
        end
      end
      LOAD: begin
        addr_term_s = LOAD_TERM;
        if (load_valid && load_ready) begin
          load_fire_s = 1'b1;
          addr_en_s   = 1'b1;
        end else begin
          load_fire_s = 1'b0;
        end
      end
      RUN: begin
        lat_term_s = TIMEOUT_TERM;
        if (END) begin
          addr_clr_s = 1'b1;
          lat_clr_s  = 1'b1;
        end else begin
          // Counting stays off when the timeout is disabled so it never wraps.
          lat_clr_s = 1'b0;
          lat_en_s  = TIMEOUT_EN;
        end
      end
      DUMP_A: begin
        lat_clr_s = 1'b0;
        lat_en_s  = 1'b1;
      end
      DUMP_O: begin
        if (dump_valid && dump_ready) begin
          dump_fire_s = 1'b1;
          addr_en_s   = !addr_at_term_s;
        end else begin
          dump_fire_s = 1'b0;
        end
      end
      default: begin
        lat_clr_s = 1'b1;
      end
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_r         <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      load_ready      <= 1'b0;
      addr_mux_select <= MUX_CORE;
      current_addr    <= 16'd0;
      mem_data        <= 16'd0;
      write_from_tb   <= 1'b0;
      ar_in           <= 16'd0;
      START           <= 1'b0;
      dump_data       <= 16'd0;
      dump_valid      <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      done          <= 1'b0;
      write_from_tb <= 1'b0;
      START         <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go) begin
            state_r         <= LOAD;
            busy            <= 1'b1;
            err             <= 1'b0;
            load_ready      <= 1'b1;
            addr_mux_select <= MUX_LOAD;
          end else begin
            state_r         <= IDLE;
            addr_mux_select <= MUX_CORE;
          end
        end
        LOAD: begin
          if (load_fire_s) begin
            current_addr  <= addr_count_s;
            mem_data      <= load_data;
            write_from_tb <= 1'b1;
            if (addr_at_term_s) begin
              state_r    <= FLUSH;
              load_ready <= 1'b0;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        FLUSH: begin
          // The last word's write strobe is visible during this cycle.
          state_r         <= STRT;
          addr_mux_select <= MUX_CORE;
          START           <= 1'b1;
        end
        STRT: begin
          state_r <= RUN;
        end
        RUN: begin
          if (END) begin
            state_r         <= DUMP_A;
            addr_mux_select <= MUX_DUMP;
            ar_in           <= 16'd0;
          end else if (TIMEOUT_EN && lat_at_term_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
          end else begin
            state_r <= RUN;
          end
        end
        DUMP_A: begin
          // ar_in was set on entry; data is valid after RD_LAT cycles.
          if (lat_at_term_s) begin
            state_r    <= DUMP_O;
            dump_data  <= dmem_rdata;
            dump_valid <= 1'b1;
          end else begin
            state_r <= DUMP_A;
          end
        end
        DUMP_O: begin
          if (dump_fire_s) begin
            dump_valid <= 1'b0;
            if (addr_at_term_s) begin
              state_r         <= IDLE;
              busy            <= 1'b0;
              done            <= 1'b1;
              addr_mux_select <= MUX_CORE;
            end else begin
              state_r <= DUMP_A;
              ar_in   <= addr_count_s + 16'd1;
            end
          end else begin
            state_r <= DUMP_O;
          end
        end
        default: begin
          state_r         <= IDLE;
          busy            <= 1'b0;
          load_ready      <= 1'b0;
          dump_valid      <= 1'b0;
          addr_mux_select <= MUX_CORE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_sequencer.sv
// Directed bench for mem_io_sequencer with LOAD_WORDS=4, DUMP_WORDS=3,
// RD_LAT=2, RUN_TIMEOUT=50. Inputs change 1 time unit after a rising edge
// and outputs are checked at that same point.
module tb_mem_io_sequencer;

  logic        clk = 1'b0;
  logic        RESET;
  logic        go;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [1:0]  addr_mux_select;
  logic [15:0] current_addr;
  logic [15:0] mem_data;
  logic        write_from_tb;
  logic [15:0] ar_in;
  logic        START;
  logic        END;
  logic [15:0] dmem_rdata;
  logic [15:0] dump_data;
  logic        dump_valid;
  logic        dump_ready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Data memory model: one register stage, content = address + 100.
  always @(posedge clk) dmem_rdata <= ar_in + 16'd100;

  mem_io_sequencer #(
    .LOAD_WORDS  (4),
    .DUMP_WORDS  (3),
    .RD_LAT      (2),
    .RUN_TIMEOUT (50)
  ) dut (
    .clk             (clk),
    .RESET           (RESET),
    .go              (go),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .addr_mux_select (addr_mux_select),
    .current_addr    (current_addr),
    .mem_data        (mem_data),
    .write_from_tb   (write_from_tb),
    .ar_in           (ar_in),
    .START           (START),
    .END             (END),
    .dmem_rdata      (dmem_rdata),
    .dump_data       (dump_data),
    .dump_valid      (dump_valid),
    .dump_ready      (dump_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET      = 1'b0;
    go         = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'd0;
    END        = 1'b0;
    dump_ready = 1'b0;

    // Reset held 3 cycles with go high.
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_mux", addr_mux_select, 0);
    chk("rst_cur_addr", current_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_wr", write_from_tb, 0);
    chk("rst_ar_in", ar_in, 0);
    chk("rst_start", START, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_dump_valid", dump_valid, 0);

    RESET = 1'b1;
    go    = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Full load, load_valid held high (ignored on the go edge).
    go         = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'd10;
    tick();
    chk("go_busy", busy, 1);
    chk("go_load_ready", load_ready, 1);
    chk("go_mux", addr_mux_select, 1);
    chk("go_no_write", write_from_tb, 0);
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("load_wr", write_from_tb, 1);
      chk("load_addr", current_addr, i);
      chk("load_data", mem_data, 10 * (i + 1));
      load_data = 16'(10 * (i + 2));
    end
    chk("flush_ready", load_ready, 0);
    chk("flush_mux", addr_mux_select, 1);
    load_valid = 1'b0;
    tick();
    chk("strt_start", START, 1);
    chk("strt_mux", addr_mux_select, 0);
    chk("strt_wr", write_from_tb, 0);
    END = 1'b1;  // already high on the first RUN cycle
    tick();
    chk("run_start_low", START, 0);
    chk("run_busy", busy, 1);
    chk("run_mux", addr_mux_select, 0);

    // Dump of 3 words with backpressure on word 1.
    tick();
    chk("dumpa_mux", addr_mux_select, 2);
    chk("dumpa_ar0", ar_in, 0);
    chk("dumpa_valid0", dump_valid, 0);
    END = 1'b0;
    tick();
    chk("dumpa2_valid0", dump_valid, 0);
    tick();
    chk("w0_valid", dump_valid, 1);
    chk("w0_data", dump_data, 100);
    dump_ready = 1'b1;
    tick();
    chk("w0_accepted", dump_valid, 0);
    chk("w1_ar", ar_in, 1);
    dump_ready = 1'b0;
    tick();
    tick();
    chk("w1_valid", dump_valid, 1);
    chk("w1_data", dump_data, 101);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("w1_stall_valid", dump_valid, 1);
      chk("w1_stall_data", dump_data, 101);
      chk("w1_stall_done", done, 0);
    end
    dump_ready = 1'b1;  // stays high: must be ignored while dump_valid=0
    tick();
    chk("w1_accepted", dump_valid, 0);
    chk("w2_ar", ar_in, 2);
    chk("w1_no_done", done, 0);
    tick();
    chk("w2_wait_valid", dump_valid, 0);
    tick();
    chk("w2_valid", dump_valid, 1);
    chk("w2_data", dump_data, 102);
    chk("w2_no_done", done, 0);
    tick();
    chk("dump_done", done, 1);
    chk("dump_busy", busy, 0);
    chk("dump_valid_drop", dump_valid, 0);
    chk("dump_mux", addr_mux_select, 0);
    dump_ready = 1'b0;
    tick();
    chk("done_single", done, 0);

    // Load with gaps, then RUN timeout.
    go = 1'b1;
    tick();
    chk("go2_busy", busy, 1);
    go = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = ((i % 2) == 0);
      load_data  = 16'h0A00 + 16'(i);
      tick();
      if ((i % 2) == 0) begin
        chk("gap_wr", write_from_tb, 1);
        chk("gap_addr", current_addr, i / 2);
        chk("gap_data", mem_data, 32'h0A00 + i);
      end else begin
        chk("gap_no_wr", write_from_tb, 0);
      end
    end
    load_valid = 1'b0;
    chk("gap_flush_ready", load_ready, 0);
    tick();
    chk("to_start", START, 1);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("to_run_busy", busy, 1);
      chk("to_run_no_done", done, 0);
    end
    tick();
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_mux", addr_mux_select, 0);
    tick();
    chk("to_done_single", done, 0);
    chk("to_err_sticky", err, 1);

    // Next go clears err; run to DUMP_O then reset.
    go = 1'b1;
    tick();
    chk("go3_err_clear", err, 0);
    chk("go3_busy", busy, 1);
    go         = 1'b0;
    load_valid = 1'b1;
    repeat (4) tick();
    load_valid = 1'b0;
    chk("go3_flush_ready", load_ready, 0);
    tick();
    chk("go3_start", START, 1);
    END = 1'b1;
    tick();
    tick();
    END = 1'b0;
    chk("go3_dump_mux", addr_mux_select, 2);
    tick();
    tick();
    chk("go3_w0_valid", dump_valid, 1);
    chk("go3_w0_data", dump_data, 100);
    RESET = 1'b0;
    tick();
    chk("mrst_valid", dump_valid, 0);
    chk("mrst_mux", addr_mux_select, 0);
    chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_start", START, 0);
    chk("mrst_wr", write_from_tb, 0);
    RESET = 1'b1;
    tick();
    chk("mrst_after_done", done, 0);
    chk("mrst_after_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
